// File: rtl/ct_had_xtrig_pkg.sv
// Shared definitions for the HAD cross-trigger hub: channel state
// encoding, counter sizing helper and default parameter values.
package ct_had_xtrig_pkg;

  typedef enum logic [1:0] {
    XT_IDLE = 2'b00,
    XT_HOLD = 2'b01,
    XT_WAIT = 2'b10
  } xt_state_e;

  localparam int XT_CORE_NUM_DEF    = 4;
  localparam int XT_PULSE_HOLD_DEF  = 4;
  localparam int XT_ACK_TIMEOUT_DEF = 16;

  // Counters only ever hold (limit-1) down to 0, so clog2 of the larger
  // limit is enough; never let the width collapse to zero.
  function automatic int xt_cnt_w(input int hold, input int tmo);
    int m;
    m = (hold > tmo) ? hold : tmo;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ct_had_xtrig_chan.sv
// One cross-trigger request channel: stretches a hit into a request that
// is held for a minimum width, then kept up until ack or timeout.
module ct_had_xtrig_chan
  import ct_had_xtrig_pkg::*;
#(
  parameter int PULSE_HOLD  = XT_PULSE_HOLD_DEF,
  parameter int ACK_TIMEOUT = XT_ACK_TIMEOUT_DEF
) (
  input  logic forever_coreclk,
  input  logic cpurst,
  input  logic hit,
  input  logic ack,
  input  logic abort,
  input  logic flush,
  output logic req,
  output logic timeout
);

  localparam int CNT_W = xt_cnt_w(PULSE_HOLD, ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(PULSE_HOLD - 1);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  xt_state_e        state;
  logic [CNT_W-1:0] cnt;

  // Channel FSM with counter; req and timeout are registered alongside state.
  always_ff @(posedge forever_coreclk or posedge cpurst) begin
    if (cpurst) begin
      state   <= XT_IDLE;
      cnt     <= '0;
      req     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (flush || abort) begin
        state <= XT_IDLE;
        cnt   <= '0;
        req   <= 1'b0;
      end else begin
        case (state)
          XT_IDLE: begin
            if (hit) begin
              state <= XT_HOLD;
              cnt   <= HOLD_LD;
              req   <= 1'b1;
            end
          end
          // Hits while busy merge silently; ack is ignored until WAIT.
          XT_HOLD: begin
            if (cnt == '0) begin
              state <= XT_WAIT;
              cnt   <= WAIT_LD;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          XT_WAIT: begin
            if (ack) begin
              state <= XT_IDLE;
              cnt   <= '0;
              req   <= 1'b0;
            end else if (cnt == '0) begin
              state   <= XT_IDLE;
              req     <= 1'b0;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state <= XT_IDLE;
            cnt   <= '0;
            req   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ct_had_xtrig_hub.sv
// Cluster cross-trigger hub: detects rising debug enter/exit events from
// each core and fans them out as held requests to the rest of the group.
module ct_had_xtrig_hub
  import ct_had_xtrig_pkg::*;
#(
  parameter int CORE_NUM    = XT_CORE_NUM_DEF,
  parameter int PULSE_HOLD  = XT_PULSE_HOLD_DEF,
  parameter int ACK_TIMEOUT = XT_ACK_TIMEOUT_DEF
) (
  input  logic                forever_coreclk,
  input  logic                cpurst,
  input  logic                cfg_xtrig_en,
  input  logic [CORE_NUM-1:0] cfg_enter_grp,
  input  logic [CORE_NUM-1:0] cfg_exit_grp,
  input  logic [CORE_NUM-1:0] x_enter_dbg_req_o,
  input  logic [CORE_NUM-1:0] x_exit_dbg_req_o,
  input  logic [CORE_NUM-1:0] core_dbgon,
  output logic [CORE_NUM-1:0] x_enter_dbg_req_i,
  output logic [CORE_NUM-1:0] x_exit_dbg_req_i,
  output logic                xtrig_busy,
  output logic [CORE_NUM-1:0] xtrig_timeout_sticky
);

  logic [CORE_NUM-1:0] prev_enter;
  logic [CORE_NUM-1:0] prev_exit;
  logic [CORE_NUM-1:0] rise_enter;
  logic [CORE_NUM-1:0] rise_exit;
  logic [CORE_NUM-1:0] bcast_enter;
  logic [CORE_NUM-1:0] bcast_exit;
  logic [CORE_NUM-1:0] hit_enter;
  logic [CORE_NUM-1:0] hit_exit;
  logic [CORE_NUM-1:0] abort_exit;
  logic [CORE_NUM-1:0] tmo_enter;
  logic [CORE_NUM-1:0] tmo_exit;
  logic                flush;

  // Previous-cycle copies of the source events for rising-edge detection.
  always_ff @(posedge forever_coreclk or posedge cpurst) begin
    if (cpurst) begin
      prev_enter <= '0;
      prev_exit  <= '0;
    end else begin
      prev_enter <= x_enter_dbg_req_o;
      prev_exit  <= x_exit_dbg_req_o;
    end
  end

  assign flush      = ~cfg_xtrig_en;
  assign rise_enter = x_enter_dbg_req_o & ~prev_enter & cfg_enter_grp & {CORE_NUM{cfg_xtrig_en}};
  assign rise_exit  = x_exit_dbg_req_o  & ~prev_exit  & cfg_exit_grp  & {CORE_NUM{cfg_xtrig_en}};

  // Broadcast matrix: every group member except the originator is targeted.
  always_comb begin
    bcast_enter = '0;
    bcast_exit  = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      for (int j = 0; j < CORE_NUM; j++) begin
        if (j != i) begin
          bcast_enter[i] = bcast_enter[i] | rise_enter[j];
          bcast_exit[i]  = bcast_exit[i]  | rise_exit[j];
        end
      end
      bcast_enter[i] = bcast_enter[i] & cfg_enter_grp[i];
      bcast_exit[i]  = bcast_exit[i]  & cfg_exit_grp[i];
    end
  end

  // Skip targets already in the requested state; enter beats a same-cycle
  // exit, and a starting enter channel kills any in-flight exit request.
  assign hit_enter  = bcast_enter & ~core_dbgon;
  assign hit_exit   = bcast_exit & core_dbgon & ~bcast_enter;
  assign abort_exit = hit_enter & ~x_enter_dbg_req_i;

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
    ct_had_xtrig_chan #(
      .PULSE_HOLD  (PULSE_HOLD),
      .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_enter (
      .forever_coreclk (forever_coreclk),
      .cpurst          (cpurst),
      .hit             (hit_enter[i]),
      .ack             (core_dbgon[i]),
      .abort           (1'b0),
      .flush           (flush),
      .req             (x_enter_dbg_req_i[i]),
      .timeout         (tmo_enter[i])
    );

    ct_had_xtrig_chan #(
      .PULSE_HOLD  (PULSE_HOLD),
      .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_exit (
      .forever_coreclk (forever_coreclk),
      .cpurst          (cpurst),
      .hit             (hit_exit[i]),
      .ack             (~core_dbgon[i]),
      .abort           (abort_exit[i]),
      .flush           (flush),
      .req             (x_exit_dbg_req_i[i]),
      .timeout         (tmo_exit[i])
    );
  end

  // Timeout flags accumulate per core until reset; disable does not clear them.
  always_ff @(posedge forever_coreclk or posedge cpurst) begin
    if (cpurst) begin
      xtrig_timeout_sticky <= '0;
    end else begin
      xtrig_timeout_sticky <= xtrig_timeout_sticky | tmo_enter | tmo_exit;
    end
  end

  assign xtrig_busy = |{x_enter_dbg_req_i, x_exit_dbg_req_i};

endmodule

// File: tb/tb_ct_had_xtrig_hub.sv
// Self-checking bench for the cross-trigger hub (4 cores, hold 4, timeout 16).
module tb_ct_had_xtrig_hub;

  logic       clk;
  logic       cpurst;
  logic       en;
  logic [3:0] eg, xg, xen_o, xex_o, dbgon;
  logic [3:0] en_i, ex_i, sticky;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_en_q[$];
  logic [3:0] exp_ex_q[$];
  logic       exp_bz_q[$];

  ct_had_xtrig_hub #(
    .CORE_NUM    (4),
    .PULSE_HOLD  (4),
    .ACK_TIMEOUT (16)
  ) dut (
    .forever_coreclk      (clk),
    .cpurst               (cpurst),
    .cfg_xtrig_en         (en),
    .cfg_enter_grp        (eg),
    .cfg_exit_grp         (xg),
    .x_enter_dbg_req_o    (xen_o),
    .x_exit_dbg_req_o     (xex_o),
    .core_dbgon           (dbgon),
    .x_enter_dbg_req_i    (en_i),
    .x_exit_dbg_req_i     (ex_i),
    .xtrig_busy           (busy),
    .xtrig_timeout_sticky (sticky)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  // Reset with default configuration; returns at posedge+1, reset released.
  task automatic do_reset();
    xen_o  = 4'b0000;
    xex_o  = 4'b0000;
    dbgon  = 4'b0000;
    en     = 1'b1;
    eg     = 4'b1111;
    xg     = 4'b1111;
    cpurst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cpurst = 1'b0;
  endtask

  task automatic test_reset();
    xen_o  = 4'b1111;
    xex_o  = 4'b1111;
    dbgon  = 4'b0000;
    en     = 1'b1;
    eg     = 4'b1111;
    xg     = 4'b1111;
    cpurst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (en_i !== 4'b0000) begin failures++; $display("FAIL reset_enter got=%b exp=0000", en_i); end
    checks++; if (ex_i !== 4'b0000) begin failures++; $display("FAIL reset_exit got=%b exp=0000", ex_i); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL reset_sticky got=%b exp=0000", sticky); end
  endtask

  // Core 0 enter pulse at c2; cores 1..3 ack at c10 -> requests c3..c10.
  task automatic test_enter_ack();
    logic [3:0] ge, gx;
    logic       gb;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      xen_o = (c == 2) ? 4'b0001 : 4'b0000;
      dbgon = (c >= 10) ? 4'b1110 : 4'b0000;
      exp_en_q.push_back((c >= 3 && c <= 10) ? 4'b1110 : 4'b0000);
      exp_ex_q.push_back(4'b0000);
      exp_bz_q.push_back(c >= 3 && c <= 10);
      @(negedge clk);
      ge = exp_en_q.pop_front(); gx = exp_ex_q.pop_front(); gb = exp_bz_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL enter_ack_en c=%0d got=%b exp=%b", c, en_i, ge); end
      checks++; if (ex_i !== gx) begin failures++; $display("FAIL enter_ack_ex c=%0d got=%b exp=%b", c, ex_i, gx); end
      checks++; if (busy !== gb) begin failures++; $display("FAIL enter_ack_busy c=%0d got=%b exp=%b", c, busy, gb); end
      @(posedge clk); #1;
    end
    checks++; if (sticky !== 4'b0000) begin failures++; $display("FAIL enter_ack_sticky got=%b exp=0000", sticky); end
  endtask

  // Core 2 never acks: bit 2 high exactly c3..c22 and its sticky bit sets.
  task automatic test_timeout();
    logic [3:0] ge, e;
    do_reset();
    for (int c = 0; c < 27; c++) begin
      xen_o = (c == 2) ? 4'b0001 : 4'b0000;
      dbgon = (c >= 10) ? 4'b1010 : 4'b0000;
      e = 4'b0000;
      if (c >= 3 && c <= 10) e = e | 4'b1010;
      if (c >= 3 && c <= 22) e = e | 4'b0100;
      exp_en_q.push_back(e);
      @(negedge clk);
      ge = exp_en_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL timeout_en c=%0d got=%b exp=%b", c, en_i, ge); end
      @(posedge clk); #1;
    end
    checks++; if (sticky !== 4'b0100) begin failures++; $display("FAIL timeout_sticky got=%b exp=0100", sticky); end
  endtask

  // Core 1 exit pulse, all in debug; core 3 acks during HOLD at c4.
  task automatic test_exit_early_ack();
    logic [3:0] gx, e;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      xex_o = (c == 2) ? 4'b0010 : 4'b0000;
      dbgon = (c >= 4) ? 4'b0111 : 4'b1111;
      e = 4'b0000;
      if (c >= 3 && c <= 22) e = e | 4'b0101;
      if (c >= 3 && c <= 7)  e = e | 4'b1000;
      exp_ex_q.push_back(e);
      @(negedge clk);
      gx = exp_ex_q.pop_front();
      checks++; if (ex_i !== gx) begin failures++; $display("FAIL exit_ack_ex c=%0d got=%b exp=%b", c, ex_i, gx); end
      checks++; if (en_i !== 4'b0000) begin failures++; $display("FAIL exit_ack_en c=%0d got=%b exp=0000", c, en_i); end
      @(posedge clk); #1;
    end
    checks++; if (sticky !== 4'b0101) begin failures++; $display("FAIL exit_ack_sticky got=%b exp=0101", sticky); end
  endtask

  // Enter from core 0 and exit from core 1 in the same cycle, mixed dbgon.
  task automatic test_same_cycle();
    logic [3:0] ge, gx;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      dbgon = 4'b0100;
      xen_o = (c == 2) ? 4'b0001 : 4'b0000;
      xex_o = (c == 2) ? 4'b0010 : 4'b0000;
      exp_en_q.push_back((c >= 3) ? 4'b1010 : 4'b0000);
      exp_ex_q.push_back(4'b0000);
      @(negedge clk);
      ge = exp_en_q.pop_front(); gx = exp_ex_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL same_cycle_en c=%0d got=%b exp=%b", c, en_i, ge); end
      checks++; if (ex_i !== gx) begin failures++; $display("FAIL same_cycle_ex c=%0d got=%b exp=%b", c, ex_i, gx); end
      @(posedge clk); #1;
    end
  endtask

  // Enter group 0011: core 0 reaches only core 1; core 2 is not a source.
  task automatic test_group_mask();
    logic [3:0] ge;
    do_reset();
    eg = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      xen_o = (c == 2) ? 4'b0001 : (c == 4) ? 4'b0100 : 4'b0000;
      exp_en_q.push_back((c >= 3) ? 4'b0010 : 4'b0000);
      @(negedge clk);
      ge = exp_en_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL group_mask_en c=%0d got=%b exp=%b", c, en_i, ge); end
      @(posedge clk); #1;
    end
  endtask

  // Enter hit on core 2 while its exit request is still in HOLD aborts it.
  task automatic test_abort();
    logic [3:0] ge, gx;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      dbgon = (c < 4) ? 4'b0100 : 4'b0000;
      xex_o = (c == 2) ? 4'b0010 : 4'b0000;
      xen_o = (c == 4) ? 4'b0001 : 4'b0000;
      exp_en_q.push_back((c >= 5) ? 4'b1110 : 4'b0000);
      exp_ex_q.push_back((c == 3 || c == 4) ? 4'b0100 : 4'b0000);
      @(negedge clk);
      ge = exp_en_q.pop_front(); gx = exp_ex_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL abort_en c=%0d got=%b exp=%b", c, en_i, ge); end
      checks++; if (ex_i !== gx) begin failures++; $display("FAIL abort_ex c=%0d got=%b exp=%b", c, ex_i, gx); end
      @(posedge clk); #1;
    end
  endtask

  // Global disable flushes active channels and blocks new events.
  task automatic test_disable();
    logic [3:0] ge;
    logic       gb;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      en    = (c >= 5) ? 1'b0 : 1'b1;
      xen_o = (c == 2) ? 4'b0001 : (c == 7) ? 4'b1000 : 4'b0000;
      exp_en_q.push_back((c >= 3 && c <= 5) ? 4'b1110 : 4'b0000);
      exp_bz_q.push_back(c >= 3 && c <= 5);
      @(negedge clk);
      ge = exp_en_q.pop_front(); gb = exp_bz_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL disable_en c=%0d got=%b exp=%b", c, en_i, ge); end
      checks++; if (busy !== gb) begin failures++; $display("FAIL disable_busy c=%0d got=%b exp=%b", c, busy, gb); end
      @(posedge clk); #1;
    end
  endtask

  // Source held 30 cycles -> one episode; then async reset mid-HOLD.
  task automatic test_held_and_reset();
    logic [3:0] ge;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      xen_o = (c >= 2 && c <= 31) ? 4'b0001 : 4'b0000;
      exp_en_q.push_back((c >= 3 && c <= 22) ? 4'b1110 : 4'b0000);
      @(negedge clk);
      ge = exp_en_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL held_en c=%0d got=%b exp=%b", c, en_i, ge); end
      @(posedge clk); #1;
    end
    do_reset();
    for (int c = 0; c < 4; c++) begin
      xen_o = (c == 2) ? 4'b0001 : 4'b0000;
      exp_en_q.push_back((c >= 3) ? 4'b1110 : 4'b0000);
      @(negedge clk);
      ge = exp_en_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL pre_rst_en c=%0d got=%b exp=%b", c, en_i, ge); end
      @(posedge clk); #1;
    end
    #2;
    cpurst = 1'b1;
    #1;
    checks++; if (en_i !== 4'b0000) begin failures++; $display("FAIL midrst_en got=%b exp=0000", en_i); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    cpurst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      exp_en_q.push_back(4'b0000);
      @(negedge clk);
      ge = exp_en_q.pop_front();
      checks++; if (en_i !== ge) begin failures++; $display("FAIL post_rst_en c=%0d got=%b exp=%b", c, en_i, ge); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_rst_busy c=%0d got=%b exp=0", c, busy); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    cpurst = 1'b1;
    en     = 1'b1;
    eg     = 4'b1111;
    xg     = 4'b1111;
    xen_o  = 4'b0000;
    xex_o  = 4'b0000;
    dbgon  = 4'b0000;
    test_reset();
    test_enter_ack();
    test_timeout();
    test_exit_early_ack();
    test_same_cycle();
    test_group_mask();
    test_abort();
    test_disable();
    test_held_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
